frame_receiver: RTL and testbench

Receive-side counterpart of `frame_sender` in the delay tester. It consumes the gig_eth_mac RX client interface (`mac_rx_data`, `mac_rx_dvld`, `mac_rx_goodframe`, `mac_rx_badframe`) and recognises test frames. For each good test frame it extracts the embedded sequence number and transmit timestamp and reports one-way delay against a shared time base. It also keeps frame and sequence-error statistics for the host.

---
 rtl/delay_tester_pkg.sv | 27 ++
 rtl/rx_field_capture.sv | 47 ++++
 rtl/frame_receiver.sv | 148 ++++++++++++++
 tb/tb_frame_receiver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_tester_pkg.sv
// Shared definitions for the delay tester: test-frame layout, defaults and RX state encoding.
package delay_tester_pkg;

  localparam logic [15:0] ETHERTYPE_DEFAULT = 16'h88B5;
  localparam int unsigned TS_W_DEFAULT      = 32;

  localparam int unsigned OFF_ETYPE    = 12;
  localparam int unsigned OFF_SEQ      = 14;
  localparam int unsigned OFF_TS       = 18;
  localparam int unsigned MIN_TEST_LEN = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FIELDS,
    ST_PAYLOAD,
    ST_WAIT_STATUS
  } rx_state_e;

  // Data-phase state implied by the number of bytes received so far.
  function automatic rx_state_e state_for_count(input logic [7:0] cnt);
    if (cnt < 8'(OFF_SEQ))           return ST_HDR;
    else if (cnt < 8'(MIN_TEST_LEN)) return ST_FIELDS;
    else                             return ST_PAYLOAD;
  endfunction

endpackage

// File: rtl/rx_field_capture.sv
// Byte-offset-indexed shift capture of the big-endian SEQ and TS fields of a test frame.
module rx_field_capture
  import delay_tester_pkg::*;
#(
  parameter int unsigned TS_W = TS_W_DEFAULT
) (
  input  logic            rx_clk,
  input  logic            reset,
  input  logic            start,
  input  logic            vld,
  input  logic [7:0]      idx,
  input  logic [7:0]      data,
  output logic [31:0]     seq,
  output logic [TS_W-1:0] ts,
  output logic [31:0]     seq_c,
  output logic [TS_W-1:0] ts_c
);

  logic [31:0]     seq_base;
  logic [TS_W-1:0] ts_base;

  // Next field values including the byte on the bus this cycle, so a frame closed
  // on its last byte sees complete fields.
  always_comb begin
    seq_base = start ? '0 : seq;
    ts_base  = start ? '0 : ts;
    seq_c    = seq_base;
    ts_c     = ts_base;
    if (vld) begin
      if (idx >= 8'(OFF_SEQ) && idx < 8'(OFF_TS))
        seq_c = {seq_base[23:0], data};
      if (idx >= 8'(OFF_TS) && idx < 8'(MIN_TEST_LEN))
        ts_c = {ts_base[TS_W-9:0], data};
    end
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      seq <= '0;
      ts  <= '0;
    end else if (vld) begin
      seq <= seq_c;
      ts  <= ts_c;
    end
  end

endmodule

// File: rtl/frame_receiver.sv
// Recognises delay-test frames on the MAC RX client interface, reports one-way delay
// and keeps frame / sequence-error statistics.
module frame_receiver
  import delay_tester_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEFAULT,
  parameter int unsigned TS_W      = TS_W_DEFAULT
) (
  input  logic            rx_clk,
  input  logic            reset,
  input  logic [TS_W-1:0] cur_time,
  input  logic [7:0]      mac_rx_data,
  input  logic            mac_rx_dvld,
  input  logic            mac_rx_goodframe,
  input  logic            mac_rx_badframe,
  output logic            result_valid,
  output logic [31:0]     result_seq,
  output logic [TS_W-1:0] result_delay,
  output logic [TS_W-1:0] cnt_good,
  output logic [TS_W-1:0] cnt_bad,
  output logic [TS_W-1:0] cnt_other,
  output logic [TS_W-1:0] cnt_seq_err
);

  rx_state_e       state;
  logic [7:0]      bcnt;
  logic            is_test;
  logic [TS_W-1:0] sof_time;
  logic            exp_valid;
  logic [31:0]     exp_seq;

  logic [31:0]     seq_r, seq_c;
  logic [TS_W-1:0] ts_r, ts_c;

  logic            status, new_frame, use_reg, close, abort, mismatch;
  logic [7:0]      idx, cnt_nx, len_v;
  logic            is_test_nx, test_v, short_v;
  logic [31:0]     seq_v;
  logic [TS_W-1:0] ts_v;

  rx_field_capture #(.TS_W(TS_W)) u_fields (
    .rx_clk (rx_clk),
    .reset  (reset),
    .start  (new_frame),
    .vld    (mac_rx_dvld),
    .idx    (idx),
    .data   (mac_rx_data),
    .seq    (seq_r),
    .ts     (ts_r),
    .seq_c  (seq_c),
    .ts_c   (ts_c)
  );

  // Per-cycle frame view; in WAIT_STATUS the closing frame is the registered one,
  // otherwise it includes the byte on the bus this cycle.
  always_comb begin
    status    = mac_rx_goodframe | mac_rx_badframe;
    new_frame = mac_rx_dvld && (state == ST_IDLE || state == ST_WAIT_STATUS);
    idx       = new_frame ? 8'd0 : bcnt;
    cnt_nx    = bcnt;
    if (new_frame)
      cnt_nx = 8'd1;
    else if (mac_rx_dvld && bcnt != 8'hFF)
      cnt_nx = bcnt + 8'd1;
    mismatch   = mac_rx_dvld &&
                 ((idx == 8'(OFF_ETYPE)     && mac_rx_data != ETHERTYPE[15:8]) ||
                  (idx == 8'(OFF_ETYPE + 1) && mac_rx_data != ETHERTYPE[7:0]));
    is_test_nx = (new_frame | is_test) & ~mismatch;
    use_reg    = (state == ST_WAIT_STATUS);
    close      = status && (state != ST_IDLE || mac_rx_dvld);
    abort      = use_reg && mac_rx_dvld && !status;
    len_v      = use_reg ? bcnt    : cnt_nx;
    test_v     = use_reg ? is_test : is_test_nx;
    seq_v      = use_reg ? seq_r   : seq_c;
    ts_v       = use_reg ? ts_r    : ts_c;
    short_v    = (len_v < 8'(MIN_TEST_LEN));
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bcnt         <= '0;
      is_test      <= 1'b1;
      sof_time     <= '0;
      exp_valid    <= 1'b0;
      exp_seq      <= '0;
      result_valid <= 1'b0;
      result_seq   <= '0;
      result_delay <= '0;
      cnt_good     <= '0;
      cnt_bad      <= '0;
      cnt_other    <= '0;
      cnt_seq_err  <= '0;
    end else begin
      result_valid <= 1'b0;

      if (mac_rx_dvld) begin
        bcnt    <= cnt_nx;
        is_test <= is_test_nx;
        if (new_frame)
          sof_time <= cur_time;
      end

      case (state)
        ST_IDLE: begin
          if (mac_rx_dvld && !status)
            state <= state_for_count(cnt_nx);
        end
        ST_WAIT_STATUS: begin
          if (mac_rx_dvld)
            state <= state_for_count(cnt_nx);
          else if (status)
            state <= ST_IDLE;
        end
        default: begin
          if (status)
            state <= ST_IDLE;
          else if (mac_rx_dvld)
            state <= state_for_count(cnt_nx);
          else
            state <= ST_WAIT_STATUS;
        end
      endcase

      if (abort)
        cnt_bad <= cnt_bad + 1'b1;

      // Classification of the frame that the status pulse closes.
      if (close) begin
        if (mac_rx_badframe) begin
          cnt_bad <= cnt_bad + 1'b1;
        end else if (short_v || !test_v) begin
          cnt_other <= cnt_other + 1'b1;
        end else begin
          cnt_good     <= cnt_good + 1'b1;
          result_valid <= 1'b1;
          result_seq   <= seq_v;
          result_delay <= sof_time - ts_v;
          if (exp_valid && seq_v != exp_seq)
            cnt_seq_err <= cnt_seq_err + 1'b1;
          exp_valid <= 1'b1;
          exp_seq   <= seq_v + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver with a frame-level reference model checked every cycle.
module tb_frame_receiver;

  typedef logic [7:0] bq_t [$];

  logic        rx_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cur_time = '0;
  logic [7:0]  mac_rx_data = '0;
  logic        mac_rx_dvld = 1'b0;
  logic        mac_rx_goodframe = 1'b0;
  logic        mac_rx_badframe = 1'b0;
  logic        result_valid;
  logic [31:0] result_seq, result_delay;
  logic [31:0] cnt_good, cnt_bad, cnt_other, cnt_seq_err;

  frame_receiver dut (
    .rx_clk           (rx_clk),
    .reset            (reset),
    .cur_time         (cur_time),
    .mac_rx_data      (mac_rx_data),
    .mac_rx_dvld      (mac_rx_dvld),
    .mac_rx_goodframe (mac_rx_goodframe),
    .mac_rx_badframe  (mac_rx_badframe),
    .result_valid     (result_valid),
    .result_seq       (result_seq),
    .result_delay     (result_delay),
    .cnt_good         (cnt_good),
    .cnt_bad          (cnt_bad),
    .cnt_other        (cnt_other),
    .cnt_seq_err      (cnt_seq_err)
  );

  always #5 rx_clk = ~rx_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rv_seen = 0;

  // Visible model (what the outputs show now) and next model (after the pending status).
  logic [31:0] mdl_good = '0, mdl_bad = '0, mdl_other = '0, mdl_err = '0, mdl_rseq = '0, mdl_rdelay = '0;
  logic        mdl_rv = 1'b0;
  logic [31:0] nxt_good = '0, nxt_bad = '0, nxt_other = '0, nxt_err = '0, nxt_rseq = '0, nxt_rdelay = '0;
  logic        nxt_rv = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_seq = '0;
  logic        open_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge rx_clk);
    #1;
    mdl_good   = nxt_good;
    mdl_bad    = nxt_bad;
    mdl_other  = nxt_other;
    mdl_err    = nxt_err;
    mdl_rseq   = nxt_rseq;
    mdl_rdelay = nxt_rdelay;
    mdl_rv     = nxt_rv;
    nxt_rv     = 1'b0;
    cur_time   = cur_time + 32'd1;
  endtask

  // Frame-level rules: length, EtherType, fields and sequence continuity.
  task automatic classify(input bq_t q, input logic [31:0] sof, input bit is_bad);
    logic [31:0] seq, ts;
    if (is_bad) begin
      nxt_bad++;
    end else if (q.size() < 22) begin
      nxt_other++;
    end else if ({q[12], q[13]} != 16'h88B5) begin
      nxt_other++;
    end else begin
      seq = {q[14], q[15], q[16], q[17]};
      ts  = {q[18], q[19], q[20], q[21]};
      nxt_good++;
      nxt_rv     = 1'b1;
      nxt_rseq   = seq;
      nxt_rdelay = sof - ts;
      if (exp_valid && seq != exp_seq) nxt_err++;
      exp_valid = 1'b1;
      exp_seq   = seq + 32'd1;
    end
  endtask

  task automatic build(output bq_t q, input logic [15:0] et, input logic [31:0] seq,
                       input logic [31:0] ts, input int len);
    q = {};
    for (int i = 0; i < len; i++) begin
      if (i == 12)                 q.push_back(et[15:8]);
      else if (i == 13)            q.push_back(et[7:0]);
      else if (i >= 14 && i < 18)  q.push_back(seq[8*(17-i) +: 8]);
      else if (i >= 18 && i < 22)  q.push_back(ts[8*(21-i) +: 8]);
      else                         q.push_back(8'(i * 7 + 3));
    end
  endtask

  // st: 0 no status, 1 good after last byte, 2 bad after last byte, 3 good on last byte.
  task automatic send_frame(input bq_t q, input logic [31:0] sof, input int st, input int gap);
    for (int i = 0; i < q.size(); i++) begin
      tick();
      if (i == 0) begin
        cur_time = sof;
        if (open_frame) begin
          nxt_bad++;
          open_frame = 1'b0;
        end
      end
      mac_rx_dvld      = 1'b1;
      mac_rx_data      = q[i];
      mac_rx_goodframe = (st == 3 && i == q.size() - 1);
      mac_rx_badframe  = 1'b0;
    end
    if (st == 3) begin
      classify(q, sof, 1'b0);
    end else if (st == 1 || st == 2) begin
      tick();
      mac_rx_dvld      = 1'b0;
      mac_rx_data      = '0;
      mac_rx_goodframe = (st == 1);
      mac_rx_badframe  = (st == 2);
      classify(q, sof, st == 2);
    end else begin
      open_frame = 1'b1;
    end
    for (int g = 0; g < gap; g++) begin
      tick();
      mac_rx_dvld      = 1'b0;
      mac_rx_goodframe = 1'b0;
      mac_rx_badframe  = 1'b0;
    end
  endtask

  task automatic do_reset();
    tick();
    reset            = 1'b1;
    mac_rx_dvld      = 1'b0;
    mac_rx_goodframe = 1'b0;
    mac_rx_badframe  = 1'b0;
    nxt_good = '0; nxt_bad = '0; nxt_other = '0; nxt_err = '0; nxt_rseq = '0; nxt_rdelay = '0; nxt_rv = 1'b0;
    mdl_good = '0; mdl_bad = '0; mdl_other = '0; mdl_err = '0; mdl_rseq = '0; mdl_rdelay = '0; mdl_rv = 1'b0;
    exp_valid  = 1'b0;
    open_frame = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge rx_clk) begin
    check("result_valid", {31'b0, result_valid}, {31'b0, mdl_rv});
    check("result_seq", result_seq, mdl_rseq);
    check("result_delay", result_delay, mdl_rdelay);
    check("cnt_good", cnt_good, mdl_good);
    check("cnt_bad", cnt_bad, mdl_bad);
    check("cnt_other", cnt_other, mdl_other);
    check("cnt_seq_err", cnt_seq_err, mdl_err);
    if (result_valid) rv_seen++;
  end

  initial begin
    bq_t q;
    tick();
    tick();
    check("rst_good", cnt_good, 32'd0);
    check("rst_rv", {31'b0, result_valid}, 32'd0);
    reset = 1'b0;

    build(q, 16'h88B5, 32'd5, 32'd100, 30);
    send_frame(q, 32'd130, 1, 2);
    check("a_seq", result_seq, 32'd5);
    check("a_delay", result_delay, 32'd30);
    check("a_good", cnt_good, 32'd1);
    check("a_pulses", rv_seen, 32'd1);
    check("a_rv_low", {31'b0, result_valid}, 32'd0);

    build(q, 16'h88B5, 32'd6, 32'd200, 30);  send_frame(q, 32'd300, 1, 0);
    build(q, 16'h88B5, 32'd7, 32'd400, 30);  send_frame(q, 32'd450, 3, 0);
    build(q, 16'h88B5, 32'd9, 32'd500, 28);  send_frame(q, 32'd560, 1, 1);
    check("seq_gap_err", cnt_seq_err, 32'd1);
    build(q, 16'h88B5, 32'hFFFFFFFF, 32'd0, 24);  send_frame(q, 32'd5, 1, 1);
    check("seq_ff_err", cnt_seq_err, 32'd2);
    build(q, 16'h88B5, 32'd0, 32'd0, 24);  send_frame(q, 32'd7, 1, 1);
    check("seq_wrap_err", cnt_seq_err, 32'd2);
    check("seq_good", cnt_good, 32'd6);

    build(q, 16'h88B5, 32'd1, 32'hFFFFFFF0, 22);
    send_frame(q, 32'h10, 3, 2);
    check("wrap_delay", result_delay, 32'h20);
    check("wrap_good", cnt_good, 32'd7);

    build(q, 16'h0800, 32'd50, 32'd0, 30);  send_frame(q, 32'd0, 1, 1);
    build(q, 16'h88B5, 32'd51, 32'd0, 16);  send_frame(q, 32'd0, 1, 1);
    build(q, 16'h88B5, 32'd52, 32'd0, 21);  send_frame(q, 32'd0, 1, 1);
    check("other_cnt", cnt_other, 32'd3);
    check("other_pulses", rv_seen, 32'd7);

    build(q, 16'h88B5, 32'd2, 32'd0, 30);    send_frame(q, 32'd0, 2, 1);
    build(q, 16'h88B5, 32'd2, 32'd0, 30);    send_frame(q, 32'd0, 0, 1);
    build(q, 16'h88B5, 32'd2, 32'd500, 26);  send_frame(q, 32'd600, 1, 2);
    check("bad_cnt", cnt_bad, 32'd2);
    check("bad_good", cnt_good, 32'd8);
    check("bad_delay", result_delay, 32'd100);
    check("bad_pulses", rv_seen, 32'd8);

    build(q, 16'h88B5, 32'd3, 32'd0, 17);
    send_frame(q, 32'd0, 0, 0);
    do_reset();
    build(q, 16'h88B5, 32'd40, 32'd0, 24);
    send_frame(q, 32'd50, 1, 2);
    check("rst_clean_good", cnt_good, 32'd1);
    check("rst_clean_bad", cnt_bad, 32'd0);
    check("rst_clean_other", cnt_other, 32'd0);
    check("rst_clean_err", cnt_seq_err, 32'd0);
    check("rst_clean_seq", result_seq, 32'd40);
    check("rst_clean_delay", result_delay, 32'd50);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
